// File: rtl/cobra_pkg.sv
// Shared types and screen geometry for the venom projectile and its hit detector.
package cobra_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_FLYING,
        ST_IMPACT,
        ST_COOLDOWN
    } state_e;

endpackage

// File: rtl/venom_hit_detect.sv
// Combinational step/strike logic: next position, target overlap and wall test.
// Overlap math is done in 11 bits so sums near the 10-bit limit cannot wrap.
module venom_hit_detect
    import cobra_pkg::*;
#(
    parameter int SPEED       = 4,
    parameter int SIZE        = 4,
    parameter int TARGET_HALF = 8
) (
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  dir_e       dir,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       target_strike,
    output logic       wall_strike
);

    localparam logic [10:0] SPEED_W = 11'(SPEED);
    localparam logic [10:0] SIZE_M1 = 11'(SIZE - 1);
    localparam logic [10:0] HALF_W  = 11'(TARGET_HALF);
    localparam logic [10:0] RIGHT_L = 11'(SCREEN_W - SIZE);
    localparam logic [10:0] DOWN_L  = 11'(SCREEN_H - SIZE);

    logic [10:0] cx, cy, nx, ny, tx, ty;
    logic [10:0] tlo_x, thi_x, tlo_y, thi_y;

    // Step along the direction, then test the stepped box against target and walls.
    always_comb begin
        cx     = {1'b0, cur_x};
        cy     = {1'b0, cur_y};
        tx     = {1'b0, target_x};
        ty     = {1'b0, target_y};
        nx     = cx;
        ny     = cy;
        next_x = cur_x;
        next_y = cur_y;
        wall_strike = 1'b0;
        unique case (dir)
            DIR_RIGHT: begin
                nx          = cx + SPEED_W;
                next_x      = cur_x + 10'(SPEED);
                wall_strike = (cx + SPEED_W) > RIGHT_L;
            end
            DIR_LEFT: begin
                nx          = cx - SPEED_W;
                next_x      = cur_x - 10'(SPEED);
                wall_strike = cx < SPEED_W;
            end
            DIR_UP: begin
                ny          = cy - SPEED_W;
                next_y      = cur_y - 10'(SPEED);
                wall_strike = cy < SPEED_W;
            end
            DIR_DOWN: begin
                ny          = cy + SPEED_W;
                next_y      = cur_y + 10'(SPEED);
                wall_strike = (cy + SPEED_W) > DOWN_L;
            end
        endcase
        // Lower hitbox bound clamps at the screen origin instead of wrapping.
        tlo_x = (tx >= HALF_W) ? (tx - HALF_W) : 11'd0;
        thi_x = tx + HALF_W;
        tlo_y = (ty >= HALF_W) ? (ty - HALF_W) : 11'd0;
        thi_y = ty + HALF_W;
        target_strike = (nx <= thi_x) && ((nx + SIZE_M1) >= tlo_x) &&
                        (ny <= thi_y) && ((ny + SIZE_M1) >= tlo_y);
    end

endmodule

// File: rtl/venom_projectile.sv
// Venom projectile: launch from the shooter, fly one step per frame, stop on
// target or wall, pulse collision/hit, then sit out a frame-counted cooldown.
module venom_projectile
    import cobra_pkg::*;
#(
    parameter int SPEED       = 4,
    parameter int SIZE        = 4,
    parameter int TARGET_HALF = 8,
    parameter int COOLDOWN    = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       venomMovement,
    input  logic [1:0] bulletDir,
    input  logic [9:0] spawnX,
    input  logic [9:0] spawnY,
    input  logic [9:0] targetX,
    input  logic [9:0] targetY,
    output logic       collision,
    output logic       hit,
    output logic [9:0] venomX,
    output logic [9:0] venomY,
    output logic       venomVisible,
    output logic [3:0] hitCount
);

    localparam int            CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN - 1);

    state_e        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    dir_e          dir_q, dir_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [3:0]    hit_count_q, hit_count_d;
    logic          collision_q, collision_d;
    logic          hit_q, hit_d;

    logic [9:0]    next_x, next_y;
    logic          target_strike, wall_strike;

    venom_hit_detect #(
        .SPEED       (SPEED),
        .SIZE        (SIZE),
        .TARGET_HALF (TARGET_HALF)
    ) u_hit_detect (
        .cur_x         (x_q),
        .cur_y         (y_q),
        .dir           (dir_q),
        .target_x      (targetX),
        .target_y      (targetY),
        .next_x        (next_x),
        .next_y        (next_y),
        .target_strike (target_strike),
        .wall_strike   (wall_strike)
    );

    // Next-state, position, cooldown and pulse logic; pulses are set on entry to Impact.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        cool_d      = cool_q;
        hit_count_d = hit_count_q;
        collision_d = 1'b0;
        hit_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (venomMovement) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                x_d     = spawnX;
                y_d     = spawnY;
                dir_d   = dir_e'(bulletDir);
                state_d = ST_FLYING;
            end
            ST_FLYING: begin
                // A dropped request aborts silently, even on a tick that would strike.
                if (!venomMovement) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if (target_strike || wall_strike) begin
                        state_d     = ST_IMPACT;
                        collision_d = 1'b1;
                        hit_d       = target_strike;
                        if (target_strike && (hit_count_q != 4'hF))
                            hit_count_d = hit_count_q + 4'd1;
                    end else begin
                        x_d = next_x;
                        y_d = next_y;
                    end
                end
            end
            ST_IMPACT: begin
                cool_d  = '0;
                state_d = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    if (cool_q == CD_LAST) begin
                        cool_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= DIR_RIGHT;
            cool_q      <= '0;
            hit_count_q <= '0;
            collision_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            cool_q      <= cool_d;
            hit_count_q <= hit_count_d;
            collision_q <= collision_d;
            hit_q       <= hit_d;
        end
    end

    assign collision    = collision_q;
    assign hit          = hit_q;
    assign venomX       = x_q;
    assign venomY       = y_q;
    assign hitCount     = hit_count_q;
    assign venomVisible = (state_q == ST_FLYING);

endmodule
